// File: rtl/apb_timer_slave.sv
// APB completer with a 32-bit prescaled down-counter timer, wait states and interrupt.
// Optional APB_TIMER_ERR_EN: illegal accesses complete with PSLVERR=1.
module apb_timer_slave #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  IRQ
);

  localparam logic [7:0] OffCtrl     = 8'h00;
  localparam logic [7:0] OffLoad     = 8'h04;
  localparam logic [7:0] OffValue    = 8'h08;
  localparam logic [7:0] OffStatus   = 8'h0C;
  localparam logic [7:0] OffPrescale = 8'h10;
  localparam logic [3:0] WaitInit    = 4'(WAIT_STATES);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e                  state_q;
  logic [3:0]              wait_q;
  logic                    en_q, en_d, reload_q, reload_d, ie_q, ie_d, exp_q, exp_d;
  logic [DATA_WIDTH-1:0]   load_q, load_d, value_q, value_d;
  logic [7:0]              prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic [7:0]              off;
  logic                    addr_ok, legal, access_done, wr_en;
  logic                    tick, expire;
  logic [DATA_WIDTH-1:0]   rdata_d;
  logic                    err_d;
  logic                    unused_paddr;

  assign off          = PADDR[7:0];
  assign unused_paddr = ^PADDR[ADDR_WIDTH-1:8];

  always_comb begin
    addr_ok = 1'b0;
    case (off)
      OffCtrl, OffLoad, OffValue, OffStatus, OffPrescale: addr_ok = 1'b1;
      default:                                            addr_ok = 1'b0;
    endcase
  end

  assign legal       = addr_ok && !(PWRITE && (off == OffValue));
  assign access_done = (state_q == StAccess) && PREADY && PSEL && PENABLE;
  assign wr_en       = access_done && PWRITE && legal;

  // Timer next state; bus writes are applied last so they win over the timer.
  always_comb begin
    en_d       = en_q;
    reload_d   = reload_q;
    ie_d       = ie_q;
    exp_d      = exp_q;
    load_d     = load_q;
    value_d    = value_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    tick       = en_q && (pcnt_q == prescale_q);
    expire     = tick && (value_q == '0);

    if (en_q) pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
    if (tick) begin
      if (value_q != '0)  value_d = value_q - 1'b1;
      else if (reload_q)  value_d = load_q;
      else                en_d    = 1'b0;
    end
    if (expire) exp_d = 1'b1;

    if (wr_en) begin
      case (off)
        OffCtrl: begin
          en_d     = PWDATA[0];
          reload_d = PWDATA[1];
          ie_d     = PWDATA[2];
          if (PWDATA[0] && !en_q) pcnt_d = 8'd0;
        end
        OffLoad: begin
          load_d  = PWDATA;
          value_d = PWDATA;
        end
        OffStatus:   if (PWDATA[0] && !expire) exp_d = 1'b0;
        OffPrescale: prescale_d = PWDATA[7:0];
        default: ;
      endcase
    end
  end

  // Read data is taken from next-state values so it shows the register during the PREADY cycle.
  always_comb begin
    rdata_d = '0;
    if (!PWRITE && legal) begin
      case (off)
        OffCtrl:     rdata_d = {{(DATA_WIDTH-3){1'b0}}, ie_d, reload_d, en_d};
        OffLoad:     rdata_d = load_d;
        OffValue:    rdata_d = value_d;
        OffStatus:   rdata_d = {{(DATA_WIDTH-1){1'b0}}, exp_d};
        OffPrescale: rdata_d = {{(DATA_WIDTH-8){1'b0}}, prescale_d};
        default:     rdata_d = '0;
      endcase
    end
`ifdef APB_TIMER_ERR_EN
    err_d = !legal;
`else
    err_d = 1'b0;
`endif
  end

  // APB FSM with registered response outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      wait_q  <= 4'd0;
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (PSEL && !PENABLE) begin
            state_q <= StAccess;
            wait_q  <= WaitInit;
            if (WaitInit == 4'd0) begin
              PREADY  <= 1'b1;
              PRDATA  <= rdata_d;
              PSLVERR <= err_d;
            end
          end
        end
        StAccess: begin
          if (!PSEL || PREADY) begin
            state_q <= StIdle;
            PREADY  <= 1'b0;
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
          end else begin
            wait_q <= wait_q - 4'd1;
            if (wait_q == 4'd1) begin
              PREADY  <= 1'b1;
              PRDATA  <= rdata_d;
              PSLVERR <= err_d;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q       <= 1'b0;
      reload_q   <= 1'b0;
      ie_q       <= 1'b0;
      exp_q      <= 1'b0;
      load_q     <= '0;
      value_q    <= '0;
      prescale_q <= 8'd0;
      pcnt_q     <= 8'd0;
      IRQ        <= 1'b0;
    end else begin
      en_q       <= en_d;
      reload_q   <= reload_d;
      ie_q       <= ie_d;
      exp_q      <= exp_d;
      load_q     <= load_d;
      value_q    <= value_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      IRQ        <= exp_q && ie_q;
    end
  end

endmodule

// File: doc/apb_timer_slave.md
# apb_timer_slave

- APB completer holding a 32-bit prescaled down-counter timer with interrupt output.
- Sits directly downstream of the AHB-to-APB bridge and occupies one slave slot: it takes one bit of the bridge's PSELx, drives one PRDATA lane, and drives one PREADY bit and one PSLVERR bit.
- Inserts a programmable number of wait states.
- Flags illegal accesses with PSLVERR.

## Interface
Parameters:
- ADDR_WIDTH, 32, APB address width; only PADDR[7:0] is decoded.
- DATA_WIDTH, 32, data width; fixed at 32.
- WAIT_STATES, 0, PREADY-low cycles per access phase, 0..15.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - HCLK  in  1  clock; the APB side runs on the bridge clock.
  - HRESETn  in  1  asynchronous active-low reset.
- APB request:
  - PSEL  in  1  slave select (this slave's PSELx bit).
  - PENABLE  in  1  access-phase strobe.
  - PWRITE  in  1  1 = write, 0 = read.
  - PADDR  in  ADDR_WIDTH  byte address.
  - PWDATA  in  32  write data.
- APB response:
  - PRDATA  out  32  read data.
  - PREADY  out  1  transfer complete.
  - PSLVERR  out  1  error response.
- IRQ  out  1  registered timer interrupt.

## Operation
Register map (offset = PADDR[7:0]):
- 0x00 CTRL, RW, reset 0.
  - bit0 EN: timer enable.
  - bit1 RELOAD: auto-reload.
  - bit2 IE: interrupt enable.
  - Other bits read 0.
- 0x04 LOAD, RW, reset 0. A write also copies PWDATA into VALUE.
- 0x08 VALUE, RO, reset 0. Current count.
- 0x0C STATUS, reset 0. bit0 EXP, write-1-to-clear.
- 0x10 PRESCALE, RW, bits[7:0], reset 0.

Illegal accesses (error response when APB_TIMER_ERR_EN is defined):
- PADDR[1:0] != 0.
- Offset not in the register map.
- Write to VALUE.
- An illegal access never alters register state.

APB FSM, states IDLE, SETUP, ACCESS:
- IDLE -> SETUP when PSEL=1 and PENABLE=0. Load wait counter with WAIT_STATES.
- SETUP -> ACCESS when PSEL=1 and PENABLE=1.
- ACCESS, wait counter non-zero: decrement; PREADY=0.
- ACCESS, wait counter zero: PREADY=1. Complete; return to IDLE, or go to SETUP if a new setup phase follows.
- PSEL deasserted in SETUP or ACCESS: return to IDLE. No register update, no response.

Timer:
- Prescale counter runs while EN=1. It produces a tick when it equals PRESCALE, then wraps to 0.
- On tick with VALUE != 0: VALUE <= VALUE - 1.
- On tick with VALUE == 0:
  - EXP <= 1.
  - RELOAD=1: VALUE <= LOAD.
  - RELOAD=0: VALUE stays 0 and EN <= 0.
- Expiry period = (LOAD+1) x (PRESCALE+1) cycles.
- Writing CTRL with EN 0->1 clears the prescale counter.
- IRQ <= EXP & IE, registered.

## Timing
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, IRQ=0. All registers at their reset values; FSM in IDLE.
- Reset asserted mid-transfer aborts the transfer immediately; no partial write lands.
- PREADY is asserted only in ACCESS with a zero wait count, so an access phase lasts WAIT_STATES+1 cycles.
- PRDATA and PSLVERR are valid only while PREADY=1 in ACCESS; otherwise both are 0.
- Writes commit on the HCLK edge ending the PREADY=1 cycle, so the new value is readable by the next transfer.
- Simultaneous expiry and STATUS W1C in the same cycle: set wins, EXP stays 1.
- Simultaneous LOAD write and tick: the write wins; VALUE = PWDATA.
- Simultaneous CTRL write and expiry with RELOAD=0: the written EN value wins.
- IRQ follows EXP & IE with one cycle of latency.
- VALUE read returns the count before that cycle's tick.

## Configuration
- Macro: APB_TIMER_ERR_EN.
- Defined: illegal accesses complete with PSLVERR=1 on the PREADY cycle; PRDATA=0.
- Undefined: PSLVERR is tied to 0. Illegal writes are silently dropped and illegal reads return 0; the same wait-state timing applies.

## Test plan
- Reset, then read every register with WAIT_STATES=0 -> all read 0x0; PREADY high on the 2nd cycle of each transfer; PSLVERR=0.
- WAIT_STATES=3: write LOAD=0x10, then read VALUE -> each access phase is 4 cycles with PREADY low for 3; VALUE=0x10.
- LOAD=4, PRESCALE=1, CTRL=0x7 -> EXP=1 after 10 enabled cycles; IRQ high 1 cycle later; VALUE reloads to 4; STATUS write 0x1 clears EXP and IRQ.
- LOAD=2, PRESCALE=0, CTRL=0x1 (one-shot) -> expires after 3 cycles; VALUE=0; CTRL reads 0x0; IRQ stays 0 (IE=0).
- With APB_TIMER_ERR_EN: write 0x5 to offset 0x08, then read offset 0x14 -> both transfers end with PSLVERR=1; VALUE unchanged. Without the macro, PSLVERR=0 and the read returns 0x0.
- PSEL dropped during ACCESS with WAIT_STATES=2 on a LOAD write -> FSM returns to IDLE; LOAD unchanged; no PREADY pulse.
